// File: rtl/seg_scan_sched.sv
// seg_scan_sched: scan scheduler for an NDIG-digit multiplexed 7-segment bank.
// Time-shares one segment bus in FREQ-clock slots, applies brightness duty and
// blanking, and double-buffers frame updates so they take effect only at frame
// boundaries.
module seg_scan_sched #(
  parameter int NDIG    = 4,
  parameter int FREQ    = 5000,
  parameter int CBITS   = 13,
  parameter int BR_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [7*NDIG-1:0]       upd_data,
  input  logic [BR_BITS-1:0]      bright,
  input  logic                    blank,
  output logic [6:0]              segment,
  output logic [NDIG-1:0]         digit_en,
  output logic [$clog2(NDIG)-1:0] digit_idx,
  output logic                    slot_tick,
  output logic                    frame_tick
);

  localparam int IW = $clog2(NDIG);
  localparam int OW = CBITS + BR_BITS + 1;

  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(FREQ - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NDIG - 1);

  logic [CBITS-1:0]         cnt, cnt_n;
  logic [IW-1:0]            idx, idx_n;
  logic [BR_BITS-1:0]       br_lat, br_n;
  logic [NDIG-1:0][6:0]     active, active_n, pend;
  logic                     pend_full, pend_full_n;
  logic                     wrap, boundary, commit, accept;
  logic [OW-1:0]            on_time;
  logic                     lit_n;
  logic [NDIG-1:0]          en_n;

  assign upd_ready = !pend_full;

  // Next-state of the scan position, brightness latch and frame buffers.
  always_comb begin
    wrap        = (cnt == CNT_LAST);
    boundary    = wrap && (idx == IDX_LAST);
    commit      = boundary && pend_full;
    accept      = upd_valid && !pend_full;
    cnt_n       = wrap ? '0 : cnt + 1'b1;
    idx_n       = idx;
    if (wrap) idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    br_n        = (cnt == '0) ? bright : br_lat;
    active_n    = commit ? pend : active;
    pend_full_n = pend_full;
    if (commit)      pend_full_n = 1'b0;
    else if (accept) pend_full_n = 1'b1;
    // Lit duration per slot; the all-ones code yields exactly FREQ.
    on_time     = ((OW'(br_n) + OW'(1)) * OW'(FREQ)) >> BR_BITS;
    lit_n       = !blank && (OW'(cnt_n) < on_time);
  end

  // One-hot digit enable of the upcoming cycle, one bit per digit.
  for (genvar g = 0; g < NDIG; g++) begin : g_en
    assign en_n[g] = lit_n && (idx_n == IW'(g));
  end

  // Scan position, brightness latch and active frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      br_lat <= '0;
      active <= '0;
    end else begin
      cnt    <= cnt_n;
      idx    <= idx_n;
      br_lat <= br_n;
      active <= active_n;
    end
  end

  // Pending frame buffer; data is captured on accept, freed on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      pend_full <= pend_full_n;
      if (accept) pend <= upd_data;
    end
  end

  // Pad outputs registered from next-state so they match the state of their cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment    <= '0;
      digit_en   <= '0;
      digit_idx  <= '0;
      slot_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      segment    <= lit_n ? active_n[idx_n] : 7'd0;
      digit_en   <= en_n;
      digit_idx  <= idx_n;
      slot_tick  <= (cnt_n == CNT_LAST);
      frame_tick <= (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: table-driven duty checks, directed handshake/blank/reset
// sequences and randomized traffic, all compared against a time-based model.
module tb_seg_scan_sched;

  localparam int NDIG = 4, FREQ = 8, CBITS = 4, BR_BITS = 3;
  localparam int FRAME = NDIG * FREQ;

  logic        clk, rst_n, upd_valid, upd_ready, blank;
  logic [27:0] upd_data;
  logic [2:0]  bright;
  logic [6:0]  segment;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;
  logic        slot_tick, frame_tick;

  seg_scan_sched #(.NDIG(NDIG), .FREQ(FREQ), .CBITS(CBITS), .BR_BITS(BR_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .bright(bright), .blank(blank), .segment(segment),
    .digit_en(digit_en), .digit_idx(digit_idx), .slot_tick(slot_tick),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: position derived from clocks elapsed since reset.
  int          c;
  int          mbr;
  logic [27:0] mact, mpend;
  bit          mpf, mfirst, macc, mblank;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    c = 0; mbr = 0; mact = '0; mpend = '0; mpf = 0; mfirst = 1; macc = 0; mblank = 0;
  endtask

  // Applies the rules for one rising edge using the inputs seen at that edge.
  task automatic model_step();
    macc = 0;
    if (c % FREQ == 0) mbr = int'(bright);
    if ((c % FRAME == FRAME - 1) && mpf) begin
      mact = mpend; mpf = 0;
    end else if (upd_valid && !mpf) begin
      mpend = upd_data; mpf = 1; macc = 1;
    end
    mblank = blank;
    c++;
    mfirst = 0;
  endtask

  task automatic check_outs();
    int cn, ix, on, een, eseg;
    bit lit;
    if (mfirst) begin
      chk("rst_digit_en", digit_en, 0);
      chk("rst_segment", segment, 0);
      chk("rst_digit_idx", digit_idx, 0);
      chk("rst_slot_tick", slot_tick, 0);
      chk("rst_frame_tick", frame_tick, 0);
      chk("rst_upd_ready", upd_ready, 1);
    end else begin
      cn   = c % FREQ;
      ix   = (c / FREQ) % NDIG;
      on   = ((mbr + 1) * FREQ) >> BR_BITS;
      lit  = !mblank && (cn < on);
      een  = lit ? (1 << ix) : 0;
      eseg = lit ? int'((mact >> (7 * ix)) & 28'h7f) : 0;
      chk("digit_en", digit_en, een);
      chk("segment", segment, eseg);
      chk("digit_idx", digit_idx, ix);
      chk("slot_tick", slot_tick, (cn == FREQ - 1) ? 1 : 0);
      chk("frame_tick", frame_tick, (c % FRAME == FRAME - 1) ? 1 : 0);
      chk("upd_ready", upd_ready, mpf ? 0 : 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  // Asynchronous reset held across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outs();
  endtask

  task automatic align(input int phase);
    int n;
    n = 0;
    while ((c % FRAME) != phase && n < 2 * FRAME) begin cyc(); n++; end
    chk("align_timeout", ((c % FRAME) == phase) ? 1 : 0, 1);
  endtask

  typedef struct { logic [2:0] br; int lit; } duty_t;
  duty_t dt[5];

  localparam logic [27:0] F1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [27:0] F2 = {7'h7F, 7'h6D, 7'h07, 7'h3F};

  initial begin
    int n, cntlit, cntslot;
    rst_n = 1'b1; upd_valid = 1'b0; upd_data = '0; bright = 3'd7; blank = 1'b0;
    model_reset();
    #3;
    do_reset();

    // Free-running scan, full brightness, empty frame.
    for (int i = 0; i < 2 * FRAME; i++) cyc();

    // First offer mid-slot 1, single-cycle valid.
    align(12);
    upd_valid = 1'b1; upd_data = F1;
    cyc();
    chk("f1_accepted", macc ? 1 : 0, 1);
    upd_valid = 1'b0; upd_data = 28'h0ABCDEF;
    for (int i = 0; i < 4; i++) cyc();

    // Second offer held off until the cycle after the commit.
    upd_valid = 1'b1; upd_data = F2;
    n = 0;
    do begin cyc(); n++; end while (!macc && n < 2 * FRAME);
    chk("f2_accept_timeout", macc ? 1 : 0, 1);
    chk("f2_accept_phase", c % FRAME, 1);
    chk("f1_digit0_shown", int'(mact[6:0]), 'h66);
    upd_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) cyc();
    chk("f2_committed", int'(mact), int'(F2));

    // Duty per brightness code, changed mid-slot, measured over the next slot.
    dt[0] = '{3'd0, 1}; dt[1] = '{3'd3, 4}; dt[2] = '{3'd7, 8};
    dt[3] = '{3'd1, 2}; dt[4] = '{3'd5, 6};
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while ((c % FREQ) != 3 && n < 2 * FREQ) begin cyc(); n++; end
      bright = dt[k].br;
      while ((c % FREQ) != FREQ - 1 && n < 4 * FREQ) begin cyc(); n++; end
      cntlit = 0;
      for (int i = 0; i < FREQ; i++) begin cyc(); if (digit_en != 0) cntlit++; end
      chk("duty_lit_clocks", cntlit, dt[k].lit);
    end

    // Blanking for 40 clocks: dark, ticks keep running.
    bright = 3'd7; blank = 1'b1; cntlit = 0; cntslot = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (digit_en != 0 || segment != 0) cntlit++;
      if (slot_tick) cntslot++;
    end
    chk("blank_dark", cntlit, 0);
    chk("blank_slot_ticks", cntslot, 5);
    blank = 1'b0;
    for (int i = 0; i < FRAME; i++) cyc();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_data  = 28'($urandom);
      bright    = 3'($urandom);
      blank     = ($urandom_range(0, 15) == 0);
      cyc();
    end
    upd_valid = 1'b0; blank = 1'b0; bright = 3'd7;

    // Reset during slot 2 with a pending frame.
    n = 0;
    while (mpf && n < 3 * FRAME) begin cyc(); n++; end
    align(17);
    upd_valid = 1'b1; upd_data = F1;
    cyc();
    upd_valid = 1'b0;
    align(20);
    chk("pend_before_rst", mpf ? 1 : 0, 1);
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
